// File: rtl/ccd_pkg.sv
// ccd_pkg: shared definitions for the CCD capture sequencer.
// Holds the default counter width, APB register offsets, CTRL/STATUS bit
// positions, register reset values and the sequencer state encoding.
package ccd_pkg;

    localparam int CNTW = 15;

    // Register offsets (byte addresses, word aligned)
    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_DELAY  = 8'h08;
    localparam logic [7:0] ADDR_SKIP   = 8'h0C;
    localparam logic [7:0] ADDR_ESHUT  = 8'h10;
    localparam logic [7:0] ADDR_FCOUNT = 8'h14;
    localparam logic [7:0] ADDR_FDONE  = 8'h18;

    // CTRL bit positions
    localparam int CTRL_START       = 0;
    localparam int CTRL_ABORT       = 1;
    localparam int CTRL_CONT        = 2;
    localparam int CTRL_START_ESHUT = 3;
    localparam int CTRL_EMBED_ESHUT = 4;
    localparam int CTRL_IRQ_EN      = 8;

    // STATUS bit positions
    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_ERR       = 2;
    localparam int STAT_STATE_LSB = 3;

    // Reset values
    localparam int          HTIME_RST  = 10;
    localparam int          VTIME_RST  = 10;
    localparam int          ESHUT_RST  = 98;
    localparam logic [3:0]  VSKIP_RST  = 4'd6;
    localparam logic [15:0] FCOUNT_RST = 16'd1;
    localparam logic        EMBED_RST  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_WAIT_RUN = 3'd2,
        S_RUNNING  = 3'd3,
        S_STOP     = 3'd4
    } seq_state_e;

endpackage

// File: rtl/ccd_seq_regs.sv
// ccd_seq_regs: APB register front-end of the CCD capture sequencer.
// Decodes zero-wait-state APB accesses, stores the configuration registers,
// implements START/ABORT self-clearing pulses, DONE/ERR write-1-to-clear
// sticky flags and the registered irq level.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   psel_i..pwdata_i      APB request; prdata_o/pslverr_o access-phase response
//   state_i, fdone_i      sequencer state and frame counter for readback
//   done_set_i/err_set_i  one-cycle set strobes from the sequencer
//   start_o/abort_o       one-cycle command pulses (write cycle)
//   cont_o..fcount_o      live register contents
//   irq_o                 registered interrupt level
module ccd_seq_regs
    import ccd_pkg::*;
#(
    parameter int CNTW = ccd_pkg::CNTW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            psel_i,
    input  logic            penable_i,
    input  logic            pwrite_i,
    input  logic [7:0]      paddr_i,
    input  logic [31:0]     pwdata_i,
    output logic [31:0]     prdata_o,
    output logic            pslverr_o,
    input  logic [2:0]      state_i,
    input  logic [15:0]     fdone_i,
    input  logic            done_set_i,
    input  logic            err_set_i,
    output logic            start_o,
    output logic            abort_o,
    output logic            cont_o,
    output logic            start_eshut_o,
    output logic            embed_eshut_o,
    output logic [CNTW-1:0] htime_o,
    output logic [CNTW-1:0] vtime_o,
    output logic [CNTW-1:0] eshut_o,
    output logic [3:0]      vskip_o,
    output logic [15:0]     fcount_o,
    output logic            irq_o
);

    logic            cont_q, cont_d, st_esh_q, st_esh_d, emb_esh_q, emb_esh_d;
    logic            irq_en_q, irq_en_d, done_q, done_d, err_q, err_d, irq_q, irq_d;
    logic [CNTW-1:0] htime_q, htime_d, vtime_q, vtime_d, eshut_q, eshut_d;
    logic [3:0]      vskip_q, vskip_d;
    logic [15:0]     fcount_q, fcount_d;

    logic access, wr;
    logic unused_pwdata;

    assign access        = psel_i & penable_i;
    assign wr            = access & pwrite_i;
    assign unused_pwdata = ^pwdata_i;

    assign start_o   = wr && (paddr_i == ADDR_CTRL) && pwdata_i[CTRL_START];
    assign abort_o   = wr && (paddr_i == ADDR_CTRL) && pwdata_i[CTRL_ABORT];
    // Only even skip factors are legal; odd writes are rejected with an error.
    assign pslverr_o = wr && (paddr_i == ADDR_SKIP) && pwdata_i[0];

    always_comb begin
        cont_d    = cont_q;
        st_esh_d  = st_esh_q;
        emb_esh_d = emb_esh_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        err_d     = err_q;
        htime_d   = htime_q;
        vtime_d   = vtime_q;
        eshut_d   = eshut_q;
        vskip_d   = vskip_q;
        fcount_d  = fcount_q;
        if (wr) begin
            case (paddr_i)
                ADDR_CTRL: begin
                    cont_d    = pwdata_i[CTRL_CONT];
                    st_esh_d  = pwdata_i[CTRL_START_ESHUT];
                    emb_esh_d = pwdata_i[CTRL_EMBED_ESHUT];
                    irq_en_d  = pwdata_i[CTRL_IRQ_EN];
                end
                ADDR_STATUS: begin
                    if (pwdata_i[STAT_DONE]) done_d = 1'b0;
                    if (pwdata_i[STAT_ERR])  err_d  = 1'b0;
                end
                ADDR_DELAY: begin
                    htime_d = pwdata_i[CNTW-1:0];
                    vtime_d = pwdata_i[16 +: CNTW];
                end
                ADDR_SKIP:   if (!pwdata_i[0]) vskip_d = pwdata_i[3:0];
                ADDR_ESHUT:  eshut_d  = pwdata_i[CNTW-1:0];
                ADDR_FCOUNT: fcount_d = pwdata_i[15:0];
                default: ;
            endcase
        end
        // A set strobe from the sequencer beats a simultaneous W1C clear.
        if (done_set_i) done_d = 1'b1;
        if (err_set_i)  err_d  = 1'b1;
        irq_d = irq_en_q & (done_q | err_q);
    end

    always_comb begin
        prdata_o = 32'd0;
        if (access && !pwrite_i) begin
            case (paddr_i)
                ADDR_CTRL: begin
                    prdata_o[CTRL_CONT]        = cont_q;
                    prdata_o[CTRL_START_ESHUT] = st_esh_q;
                    prdata_o[CTRL_EMBED_ESHUT] = emb_esh_q;
                    prdata_o[CTRL_IRQ_EN]      = irq_en_q;
                end
                ADDR_STATUS: begin
                    prdata_o[STAT_BUSY]                   = (state_i != 3'd0);
                    prdata_o[STAT_DONE]                   = done_q;
                    prdata_o[STAT_ERR]                    = err_q;
                    prdata_o[STAT_STATE_LSB +: 3]         = state_i;
                end
                ADDR_DELAY: begin
                    prdata_o[CNTW-1:0]  = htime_q;
                    prdata_o[16 +: CNTW] = vtime_q;
                end
                ADDR_SKIP:   prdata_o[3:0]      = vskip_q;
                ADDR_ESHUT:  prdata_o[CNTW-1:0] = eshut_q;
                ADDR_FCOUNT: prdata_o[15:0]     = fcount_q;
                ADDR_FDONE:  prdata_o[15:0]     = fdone_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cont_q    <= 1'b0;
            st_esh_q  <= 1'b0;
            emb_esh_q <= EMBED_RST;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
            htime_q   <= CNTW'(HTIME_RST);
            vtime_q   <= CNTW'(VTIME_RST);
            eshut_q   <= CNTW'(ESHUT_RST);
            vskip_q   <= VSKIP_RST;
            fcount_q  <= FCOUNT_RST;
        end else begin
            cont_q    <= cont_d;
            st_esh_q  <= st_esh_d;
            emb_esh_q <= emb_esh_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
            htime_q   <= htime_d;
            vtime_q   <= vtime_d;
            eshut_q   <= eshut_d;
            vskip_q   <= vskip_d;
            fcount_q  <= fcount_d;
        end
    end

    assign cont_o        = cont_q;
    assign start_eshut_o = st_esh_q;
    assign embed_eshut_o = emb_esh_q;
    assign htime_o       = htime_q;
    assign vtime_o       = vtime_q;
    assign eshut_o       = eshut_q;
    assign vskip_o       = vskip_q;
    assign fcount_o      = fcount_q;
    assign irq_o         = irq_q;

endmodule

// File: rtl/ccd_capture_seq.sv
// ccd_capture_seq: capture sequencer for the CCD timing generator.
// Runs single-shot, N-frame and continuous captures, freezes the timing
// configuration into output shadows at START, counts frame starts and
// reports DONE/ERR through the register block (ccd_seq_regs).
// Optional watchdog: define CCD_SEQ_WDT_EN to abandon a run that waits more
// than WDT_CYCLES cycles in WAIT_RUN or STOP (sets ERR, returns to IDLE).
// Ports: clk/rst; APB slave (psel..pslverr); tgen_running/tgen_frame_start
// status in; tgen_en, shutter modes and timing config out; irq level out.
module ccd_capture_seq
    import ccd_pkg::*;
#(
    parameter int          CNTW       = ccd_pkg::CNTW,
    parameter logic [23:0] WDT_CYCLES = 24'd1_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            psel,
    input  logic            penable,
    input  logic            pwrite,
    input  logic [7:0]      paddr,
    input  logic [31:0]     pwdata,
    output logic [31:0]     prdata,
    output logic            pready,
    output logic            pslverr,
    input  logic            tgen_running,
    input  logic            tgen_frame_start,
    output logic            tgen_en,
    output logic            tgen_start_eshut,
    output logic            tgen_embed_eshut,
    output logic [CNTW-1:0] delay_htime,
    output logic [CNTW-1:0] delay_vtime,
    output logic [CNTW-1:0] eshut_line,
    output logic [3:0]      vskip,
    output logic            irq
);

    seq_state_e      state_q, state_d;
    logic [15:0]     fdone_q, fdone_d, fdone_inc, fcount_eff;
    logic            tgen_en_q, tgen_en_d;
    logic            done_set, err_set, load_shadow;

    logic            start, abort, cont, r_st_esh, r_emb_esh;
    logic [CNTW-1:0] r_htime, r_vtime, r_eshut;
    logic [3:0]      r_vskip;
    logic [15:0]     r_fcount;

    // Output shadows, loaded only when a run starts from IDLE
    logic            sh_st_esh_q, sh_emb_esh_q;
    logic [CNTW-1:0] sh_htime_q, sh_vtime_q, sh_eshut_q;
    logic [3:0]      sh_vskip_q;
    logic [15:0]     sh_fcount_q;

    assign pready = 1'b1;

    ccd_seq_regs #(.CNTW(CNTW)) u_regs (
        .clk_i         (clk),
        .rst_i         (rst),
        .psel_i        (psel),
        .penable_i     (penable),
        .pwrite_i      (pwrite),
        .paddr_i       (paddr),
        .pwdata_i      (pwdata),
        .prdata_o      (prdata),
        .pslverr_o     (pslverr),
        .state_i       (state_q),
        .fdone_i       (fdone_q),
        .done_set_i    (done_set),
        .err_set_i     (err_set),
        .start_o       (start),
        .abort_o       (abort),
        .cont_o        (cont),
        .start_eshut_o (r_st_esh),
        .embed_eshut_o (r_emb_esh),
        .htime_o       (r_htime),
        .vtime_o       (r_vtime),
        .eshut_o       (r_eshut),
        .vskip_o       (r_vskip),
        .fcount_o      (r_fcount),
        .irq_o         (irq)
    );

    assign fdone_inc  = (fdone_q == 16'hFFFF) ? fdone_q : fdone_q + 16'd1;
    assign fcount_eff = (sh_fcount_q == 16'd0) ? 16'd1 : sh_fcount_q;

`ifdef CCD_SEQ_WDT_EN
    logic [23:0] wdt_q, wdt_d;
    logic        wdt_hit;
    assign wdt_hit = ((state_q == S_WAIT_RUN) || (state_q == S_STOP)) &&
                     (wdt_q == WDT_CYCLES - 24'd1);
`else
    logic unused_wdt;
    assign unused_wdt = ^WDT_CYCLES;
`endif

    // tgen_en is registered and driven from the decision taken this cycle, so
    // it rises one edge after the FSM leaves IDLE and falls on the same edge
    // the FSM enters STOP.
    always_comb begin
        state_d     = state_q;
        fdone_d     = fdone_q;
        tgen_en_d   = 1'b0;
        done_set    = 1'b0;
        err_set     = 1'b0;
        load_shadow = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d     = S_ARM;
                    fdone_d     = 16'd0;
                    load_shadow = 1'b1;
                end
            end
            S_ARM: begin
                if (abort) state_d = S_STOP;
                else begin
                    state_d   = S_WAIT_RUN;
                    tgen_en_d = 1'b1;
                end
            end
            S_WAIT_RUN: begin
                if (abort) state_d = S_STOP;
                else begin
                    tgen_en_d = 1'b1;
                    if (tgen_running) state_d = S_RUNNING;
                end
            end
            S_RUNNING: begin
                // The frame is counted even when it coincides with ABORT.
                if (tgen_frame_start) fdone_d = fdone_inc;
                if (abort || (!cont && (fdone_d >= fcount_eff))) state_d = S_STOP;
                else tgen_en_d = 1'b1;
            end
            S_STOP: begin
                if (!tgen_running) begin
                    state_d  = S_IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef CCD_SEQ_WDT_EN
        if (wdt_hit) begin
            state_d   = S_IDLE;
            tgen_en_d = 1'b0;
            done_set  = 1'b0;
            err_set   = 1'b1;
        end
        if (state_d != state_q) wdt_d = 24'd0;
        else if ((state_q == S_WAIT_RUN) || (state_q == S_STOP)) wdt_d = wdt_q + 24'd1;
        else wdt_d = 24'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fdone_q      <= 16'd0;
            tgen_en_q    <= 1'b0;
            sh_st_esh_q  <= 1'b0;
            sh_emb_esh_q <= EMBED_RST;
            sh_htime_q   <= CNTW'(HTIME_RST);
            sh_vtime_q   <= CNTW'(VTIME_RST);
            sh_eshut_q   <= CNTW'(ESHUT_RST);
            sh_vskip_q   <= VSKIP_RST;
            sh_fcount_q  <= FCOUNT_RST;
`ifdef CCD_SEQ_WDT_EN
            wdt_q        <= 24'd0;
`endif
        end else begin
            state_q   <= state_d;
            fdone_q   <= fdone_d;
            tgen_en_q <= tgen_en_d;
            if (load_shadow) begin
                sh_st_esh_q  <= r_st_esh;
                sh_emb_esh_q <= r_emb_esh;
                sh_htime_q   <= r_htime;
                sh_vtime_q   <= r_vtime;
                sh_eshut_q   <= r_eshut;
                sh_vskip_q   <= r_vskip;
                sh_fcount_q  <= r_fcount;
            end
`ifdef CCD_SEQ_WDT_EN
            wdt_q <= wdt_d;
`endif
        end
    end

    assign tgen_en          = tgen_en_q;
    assign tgen_start_eshut = sh_st_esh_q;
    assign tgen_embed_eshut = sh_emb_esh_q;
    assign delay_htime      = sh_htime_q;
    assign delay_vtime      = sh_vtime_q;
    assign eshut_line       = sh_eshut_q;
    assign vskip            = sh_vskip_q;

endmodule
